// File: rtl/data_ram_responder.sv
// Wait-state data RAM responder for the CPU memory-control stage.
// Optional feature macro: RAM_PARITY_EN (per-word even parity check).
module data_ram_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        req,
  input  logic        RW,
  input  logic [31:0] address_out,
  input  logic [31:0] RAM_in,
  output logic [31:0] RAM_out,
  output logic        ready,
  output logic        busy,
  output logic        addr_err,
  output logic        parity_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ram_out_q, ram_out_d;

  logic [31:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic [31:0]           rd_word;
  logic                  we;

  assign idx      = addr_q[DEPTH_LOG2-1:0];
  assign in_range = (addr_q[31:DEPTH_LOG2] == '0);
  assign rd_word  = mem_q[idx];

  // Writes commit on the edge that ends RESP so a reset in RESP aborts them.
  assign we = (state_q == RESP) && !rw_q && in_range && Reset_n;

  // Next-state, transaction latch and read-data load.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ram_out_d = ram_out_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          rw_d    = RW;
          addr_d  = address_out;
          wdata_d = RAM_in;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (rw_q) begin
          ram_out_d = in_range ? rd_word : 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rw_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      ram_out_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ram_out_q <= ram_out_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata_q;
    end
  end

`ifdef RAM_PARITY_EN
  logic par_q [DEPTH];

  // Even-parity bit stored alongside each written word.
  always_ff @(posedge clk) begin
    if (we) begin
      par_q[idx] <= ^wdata_q;
    end
  end

  assign parity_err = (state_q == RESP) && rw_q && in_range &&
                      ((^rd_word) != par_q[idx]);
`else
  assign parity_err = 1'b0;
`endif

  assign RAM_out  = ram_out_q;
  assign ready    = (state_q == RESP);
  assign busy     = (state_q != IDLE);
  assign addr_err = (state_q == RESP) && !in_range;

endmodule
